fetch_pc_gen: RTL

- Parametrised successor of the single-issue PC register in the fetch stage.
- Generates group-aligned fetch addresses of FETCH_W instructions per fetch.
- Runs a req/gnt/rvalid handshake with the instruction memory and merges exception and branch redirects by priority.
- Drops stale responses after a redirect, and holds the fetched packet until decode accepts it.

---
 rtl/fetch_pc_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: group-aligned fetch PC generator with imem handshake, redirect merge and packet hold
module fetch_pc_gen #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] START_ADDR = 32'h1c000000,
    parameter int FETCH_W = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [XLEN:0]          excp_bus_i,
    input  logic [XLEN:0]          jbr_bus_i,
    output logic                   imem_req_o,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [32*FETCH_W-1:0]  imem_rdata_i,
    input  logic                   id_allow_i,
    output logic                   if_valid_o,
    output logic [XLEN-1:0]        if_pc_o,
    output logic [XLEN-1:0]        if_nxt_pc_o,
    output logic [32*FETCH_W-1:0]  if_inst_o,
    output logic [FETCH_W-1:0]     if_mask_o,
    output logic                   if_adef_o
);
    localparam int OFS = $clog2(FETCH_W) + 2;
    localparam int SW = (FETCH_W == 1) ? 1 : OFS - 2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    state_t state, state_nxt;
    logic [XLEN-1:0] pc, pc_grp, seq_pc, tgt;
    logic redir, mis, drop, adef;
    logic [32*FETCH_W-1:0] inst;
    logic [FETCH_W-1:0] slot_mask;

    assign redir  = excp_bus_i[XLEN] | jbr_bus_i[XLEN];
    assign tgt    = excp_bus_i[XLEN] ? excp_bus_i[XLEN-1:0] : jbr_bus_i[XLEN-1:0];
    assign pc_grp = {pc[XLEN-1:OFS], OFS'(0)};
    assign seq_pc = pc_grp + XLEN'(4 * FETCH_W);
    assign mis    = |pc[1:0];

    generate
        if (FETCH_W == 1) begin : g_one
            assign slot_mask = 1'b1;
        end else begin : g_multi
            for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
                assign slot_mask[i] = SW'(i) >= pc[OFS-1:2];
            end
        end
    endgenerate

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next state: redirects restart fetching, misaligned pc bypasses memory as an ADEF packet
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   state_nxt = mis ? (redir ? S_REQ : S_OUT) : (imem_gnt_i ? S_WAIT : S_REQ);
            S_WAIT:  state_nxt = imem_rvalid_i ? ((drop || redir) ? S_REQ : S_OUT) : S_WAIT;
            S_OUT:   state_nxt = (redir || id_allow_i) ? S_REQ : S_OUT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // pc, stale-response drop flag and captured packet
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc   <= START_ADDR;
            drop <= 1'b0;
            adef <= 1'b0;
            inst <= '0;
        end else begin
            if (redir) pc <= tgt;
            else if (state == S_OUT && id_allow_i) pc <= seq_pc;
            drop <= (state == S_WAIT) ? (!imem_rvalid_i && (drop || redir))
                                      : (state == S_REQ && !mis && imem_gnt_i && redir);
            if (state == S_REQ) adef <= mis;
            if (state == S_WAIT && imem_rvalid_i && !drop && !redir) inst <= imem_rdata_i;
            else if (state == S_REQ && mis && !redir) inst <= '0;
        end
    end

    // outputs decoded from the registered state and pc
    always_comb begin
        imem_req_o  = state == S_REQ && !mis;
        imem_addr_o = pc_grp;
        if_valid_o  = state == S_OUT;
        if_pc_o     = pc;
        if_nxt_pc_o = redir ? tgt : seq_pc;
        if_inst_o   = inst;
        if_adef_o   = (state == S_OUT) && adef;
        if_mask_o   = (state != S_OUT) ? '0 : adef ? FETCH_W'(1) : slot_mask;
    end
endmodule
